rf_write_sequencer: RTL and testbench
=====================================

# rf_write_sequencer

Write-side master for the 32x32 three-port register file: it collects writeback results from the ALU and the load/store unit, queues them in order, and drives the file's single write port (`RW`, `PW`, `LE`) with one write per clock. It sits between the execute/memory stages and the register file, so the file's single write port never sees a collision. It also enforces the SPARC hardwired-zero rule: writes to r0 never reach the file.

## Interface
- `DEPTH`, 4, number of queue entries; power of two, at least 2.
- `clk` in 1: rising-edge clock, shared with the register file.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU writeback request.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `alu_ready` out 1: ALU request accepted this cycle when both `alu_valid` and `alu_ready` are 1.
- `mem_valid` in 1: load writeback request.
- `mem_rd` in 5: load destination register.
- `mem_data` in 32: load data.
- `mem_ready` out 1: load request accepted when both `mem_valid` and `mem_ready` are 1.
- `RW` out 5: register file write select.
- `PW` out 32: register file write data.
- `LE` out 1: register file load enable.
- `busy` out 1: queue non-empty.
- `fwd_rs` in 5: forwarding lookup register. Only meaningful with the forwarding macro.
- `fwd_hit` out 1: a queued entry matches `fwd_rs`.
- `fwd_data` out 32: data of the youngest matching entry.

## Operation
- The queue is a circular buffer of `DEPTH` entries, each {rd[4:0], data[31:0]}. It has a head pointer, a tail pointer and a count of `log2(DEPTH)+1` bits.
- `free = DEPTH - count`, computed from the registered count only. A dequeue in the same cycle gives no credit.
- `mem_ready = (free >= 1)`.
- `alu_ready = (free >= 2) | ((free == 1) & ~mem_valid)`. The load path has priority for the last slot.
- Same-cycle acceptance of both requests: the mem entry is enqueued first (older), then the alu entry.
- A request with rd == 0 is handshaken normally: ready follows the same rule and the source sees acceptance. It is discarded without occupying a slot or changing the count.
- Dequeue: whenever count > 0, `LE = 1`, `RW = head.rd`, `PW = head.data`. The head pops at the next rising edge, the same edge the file captures the write.
- Whenever count == 0, `LE = 0`, `RW = 0` and `PW = 0`.
- Outputs are combinational from the registered head entry; there is no combinational path from the requests to `LE`/`RW`/`PW`.
- `busy = (count != 0)`.
- Count update: count += enqueued entries minus pops; at most 2 enqueued and 1 popped per cycle.
- Pointers wrap modulo `DEPTH`.
- Duplicate destinations are allowed. The entries are written in queue order, so the younger value wins in the file.

## Timing
- Reset is asynchronous and active-low. It clears count and both pointers, so `LE`, `RW`, `PW`, `busy`, `fwd_hit` and `fwd_data` are all 0 while `rst_n` is low.
- Reset mid-operation drops all queued entries; no partial write is issued afterward.
- Latency: a request accepted at edge N drives `LE` during cycle N..N+1 if the queue was empty. It is written into the file at edge N+1.
- Throughput is one file write per cycle. A sustained two-source input fills the queue, after which ready deasserts.
- Full (count == `DEPTH`): both readies are 0; the head is still written and popped that cycle.
- Empty, with both requests valid: both are accepted, and the mem entry is written first.
- Sources must hold rd/data stable while valid is high and ready is low.

## Configuration
- `RF_WSEQ_FWD_EN` defined:
  - `fwd_hit`/`fwd_data` compare `fwd_rs` against all valid entries, combinationally.
  - The youngest match wins; `fwd_rs == 0` never hits.
  - The readers use this to see pending writebacks before the file is updated.
- Not defined: `fwd_hit = 0`, `fwd_data = 0`, no compare logic; `fwd_rs` is ignored.

## Structure
- The shared package holds:
  - the entry typedef {rd, data};
  - `RF_ADDR_W = 5` and `RF_DATA_W = 32`;
  - `RF_ZERO_REG = 0`;
  - the default `DEPTH`.
- One sub-module, `wseq_fifo`:
  - dual-push, single-pop storage with pointers and count;
  - exposes all entries and valid bits for the forwarding compare.
- The top level holds the ready logic, the r0 filter, the write-port drive and the forwarding mux.

## Test plan
- Single write: from reset, `alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF` for one cycle. Required: next cycle `LE=1, RW=5, PW=0xDEADBEEF`; the cycle after, `LE=0`, `busy=0`.
- Ordering: simultaneous `mem (rd=3, 0x11)` and `alu (rd=3, 0x22)`. Required: `LE` writes `0x11` then `0x22` on consecutive cycles, so r3 ends at `0x22`.
- r0 drop: `alu_rd=0, alu_data=0xFFFFFFFF` accepted. Required: `alu_ready=1`, `LE` stays 0, `busy` stays 0.
- Full, with `DEPTH=4`: fill 4 entries while the sink pops. Required: `alu_ready` drops at free==1 when `mem_valid=1`; `mem_ready=0` at count==4; no entry lost and none duplicated, checked by a scoreboard.
- Async reset: assert `rst_n=0` mid-cycle with 3 entries queued. Required: `LE`, `RW`, `PW` and `busy` go 0 immediately; no write of the old entries after release.
- Forwarding, with `RF_WSEQ_FWD_EN`: queue `rd=7:0xA`, then `rd=7:0xB`, and set `fwd_rs=7`. Required: `fwd_hit=1, fwd_data=0xB`. With `fwd_rs=0`: `fwd_hit=0`.

Source files
------------

// File: rtl/rf_write_sequencer_pkg.sv
// Shared types and constants for the register-file write sequencer.
package rf_write_sequencer_pkg;

  localparam int unsigned RF_ADDR_W     = 5;
  localparam int unsigned RF_DATA_W     = 32;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = '0;
  localparam int unsigned RF_WSEQ_DEPTH = 4;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/rf_write_sequencer_fifo.sv
// Dual-push, single-pop circular queue of writeback entries.
// Entries are exposed oldest-first (ages[0] is the head) with per-slot valid bits.
module wseq_fifo
  import rf_write_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = RF_WSEQ_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_a,
  input  entry_t                    entry_a,
  input  logic                      push_b,
  input  entry_t                    entry_b,
  input  logic                      pop,
  output logic [$clog2(DEPTH):0]    count,
  output entry_t [DEPTH-1:0]        ages,
  output logic [DEPTH-1:0]          age_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             pop_eff;

  assign pop_eff = pop & (count != '0);

  // Entry a is the older one when both push; entry b lands after it.
  always_ff @(posedge clk) begin
    if (push_a) mem[tail] <= entry_a;
    if (push_b) mem[tail + PTR_W'(push_a)] <= entry_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PTR_W'(push_a) + PTR_W'(push_b);
      if (pop_eff) head <= head + PTR_W'(1);
      count <= count + CW'(push_a) + CW'(push_b) - CW'(pop_eff);
    end
  end

  always_comb begin
    ages      = '0;
    age_valid = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      ages[k]      = mem[head + PTR_W'(k)];
      age_valid[k] = (CW'(k) < count);
    end
  end

endmodule

// File: rtl/rf_write_sequencer.sv
// Write-port master for the 32x32 register file: queues ALU/load writebacks, drops r0.
// Optional pending-write forwarding is enabled by defining RF_WSEQ_FWD_EN.
module rf_write_sequencer
  import rf_write_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = RF_WSEQ_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [RF_ADDR_W-1:0] alu_rd,
  input  logic [RF_DATA_W-1:0] alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [RF_ADDR_W-1:0] mem_rd,
  input  logic [RF_DATA_W-1:0] mem_data,
  output logic                 mem_ready,
  output logic [RF_ADDR_W-1:0] RW,
  output logic [RF_DATA_W-1:0] PW,
  output logic                 LE,
  output logic                 busy,
  input  logic [RF_ADDR_W-1:0] fwd_rs,
  output logic                 fwd_hit,
  output logic [RF_DATA_W-1:0] fwd_data
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]      count;
  logic [CW-1:0]      free;
  entry_t [DEPTH-1:0] ages;
  logic [DEPTH-1:0]   age_valid;
  logic               push_mem;
  logic               push_alu;

  // Free space ignores this cycle's pop; the load path owns the last slot.
  assign free      = CW'(DEPTH) - count;
  assign mem_ready = (free >= CW'(1));
  assign alu_ready = (free >= CW'(2)) | ((free == CW'(1)) & ~mem_valid);

  assign push_mem = mem_valid & mem_ready & (mem_rd != RF_ZERO_REG);
  assign push_alu = alu_valid & alu_ready & (alu_rd != RF_ZERO_REG);

  wseq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_a    (push_mem),
    .entry_a   ('{rd: mem_rd, data: mem_data}),
    .push_b    (push_alu),
    .entry_b   ('{rd: alu_rd, data: alu_data}),
    .pop       (busy),
    .count     (count),
    .ages      (ages),
    .age_valid (age_valid)
  );

  assign busy = (count != '0);
  assign LE   = busy;
  assign RW   = busy ? ages[0].rd   : '0;
  assign PW   = busy ? ages[0].data : '0;

`ifdef RF_WSEQ_FWD_EN
  // Scan oldest to youngest so the youngest match is left standing.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (age_valid[k] && (ages[k].rd == fwd_rs) && (fwd_rs != RF_ZERO_REG)) begin
        fwd_hit  = 1'b1;
        fwd_data = ages[k].data;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_rs, ages, age_valid};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_rf_write_sequencer.sv
// Scoreboard bench for rf_write_sequencer: expected writes queued on acceptance, checked on LE.
module tb_rf_write_sequencer;
  import rf_write_sequencer_pkg::*;

  localparam int unsigned DEPTH = RF_WSEQ_DEPTH;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd, fwd_rs;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic [4:0]  RW;
  logic [31:0] PW;
  logic        LE, busy, fwd_hit;
  logic [31:0] fwd_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  entry_t      sb[$];

  rf_write_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .RW(RW), .PW(PW), .LE(LE), .busy(busy),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no end of run, required $finish within budget");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_LE"},   LE,       0);
    chk({tag, "_RW"},   RW,       0);
    chk({tag, "_PW"},   PW,       0);
    chk({tag, "_busy"}, busy,     0);
    chk({tag, "_fhit"}, fwd_hit,  0);
    chk({tag, "_fdat"}, fwd_data, 0);
  endtask

  function automatic logic [4:0] pick_rd();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd3;
      2:       return 5'd7;
      default: return 5'($urandom_range(1, 31));
    endcase
  endfunction

  // Drive one cycle's requests at the falling edge, check, then advance the model past the rising edge.
  task automatic cycle(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic [4:0] rs, output logic acc_m, output logic acc_a);
    int unsigned free;
    logic        exp_mr, exp_ar, exp_hit;
    logic [31:0] exp_fd;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    fwd_rs    = rs;
    #1;
    free   = DEPTH - sb.size();
    exp_mr = (free >= 1);
    exp_ar = (free >= 2) || ((free == 1) && !mv);
    chk("mem_ready", mem_ready, exp_mr);
    chk("alu_ready", alu_ready, exp_ar);
    chk("busy", busy, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("LE", LE, 1);
      chk("RW", RW, sb[0].rd);
      chk("PW", PW, sb[0].data);
    end else begin
      chk("LE_idle", LE, 0);
      chk("RW_idle", RW, 0);
      chk("PW_idle", PW, 0);
    end
    exp_hit = 1'b0;
    exp_fd  = '0;
`ifdef RF_WSEQ_FWD_EN
    foreach (sb[i]) if (rs != 0 && sb[i].rd == rs) begin exp_hit = 1'b1; exp_fd = sb[i].data; end
`endif
    chk("fwd_hit", fwd_hit, exp_hit);
    chk("fwd_data", fwd_data, exp_fd);
    if (sb.size() != 0) void'(sb.pop_front());
    acc_m = mv && exp_mr;
    acc_a = av && exp_ar;
    if (acc_m && mrd != 0) sb.push_back('{rd: mrd, data: md});
    if (acc_a && ard != 0) sb.push_back('{rd: ard, data: ad});
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    logic am, aa;
    for (int unsigned i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 5'd7, am, aa);
  endtask

  // Sources hold rd/data while stalled; new requests only after acceptance.
  task automatic traffic(input int unsigned n, input bit force_valid);
    logic        m_v, a_v, am, aa;
    logic [4:0]  m_rd, a_rd;
    logic [31:0] m_d, a_d;
    m_v = 0; a_v = 0; am = 1; aa = 1; m_rd = 0; a_rd = 0; m_d = 0; a_d = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (!m_v || am) begin
        m_v = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
        m_rd = force_valid ? 5'(1 + (i % 31)) : pick_rd();
        m_d = $urandom;
      end
      if (!a_v || aa) begin
        a_v = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
        a_rd = force_valid ? 5'(1 + ((i + 9) % 31)) : pick_rd();
        a_d = $urandom;
      end
      cycle(m_v, m_rd, m_d, a_v, a_rd, a_d, pick_rd(), am, aa);
    end
  endtask

  initial begin
    logic am, aa;
    rst_n = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0; fwd_rs = 5'd7;
    #1;
    chk_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;

    // single write
    cycle(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 5'd5, am, aa);
    idle(2);

    // same-cycle ordering: mem older than alu
    cycle(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 5'd3, am, aa);
    idle(3);

    // r0 writes handshake but never queue
    cycle(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, am, aa);
    chk("r0_acc", aa, 1);
    idle(1);

    // sustained dual-source pressure, then random mix
    traffic(12, 1'b1);
    idle(DEPTH + 1);
    traffic(60, 1'b0);
    idle(DEPTH + 1);

    // async reset with three entries queued
    cycle(1, 5'd10, 32'hA0, 1, 5'd11, 32'hA1, 5'd10, am, aa);
    cycle(1, 5'd12, 32'hA2, 1, 5'd13, 32'hA3, 5'd12, am, aa);
    chk("pre_reset_depth", sb.size(), 3);
    mem_valid = 0; alu_valid = 0;
    #2 rst_n = 0;
    #1;
    chk_idle_outputs("async_rst");
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    idle(3);

    // forwarding: youngest of two queued r7 entries
    cycle(1, 5'd7, 32'hA, 1, 5'd7, 32'hB, 5'd7, am, aa);
    cycle(0, 0, 0, 0, 0, 0, 5'd7, am, aa);
    cycle(0, 0, 0, 0, 0, 0, 5'd0, am, aa);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
